// File: rtl/usr_serial_tx_ctrl.sv
// Serial transmit controller for an n-bit universal shift register.
// Loads a word into the USR and streams it out bit by bit under backpressure.
module usr_serial_tx_ctrl #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [n-1:0] in_data,
  input  logic         in_msb_first,
  input  logic         in_fill,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [1:0]   usr_s,
  output logic [n-1:0] usr_I,
  output logic         usr_MSB_in,
  output logic         usr_LSB_in,
  input  logic [n-1:0] usr_Q,
  output logic         ser_bit,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         done
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FIN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [n-1:0]  data_reg;
  logic          dir_reg;
  logic          fill_reg;
  logic          take;

  assign take = (state == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      data_reg <= '0;
      dir_reg  <= 1'b0;
      fill_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (take) begin
        data_reg <= in_data;
        dir_reg  <= in_msb_first;
        fill_reg <= in_fill;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    in_ready  = 1'b0;
    usr_s     = 2'b00;
    usr_I     = '0;
    ser_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        usr_s     = 2'b11;
        usr_I     = data_reg;
        count_nxt = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          usr_s     = dir_reg ? 2'b10 : 2'b01;
          count_nxt = count + CW'(1);
          if (count == LAST) state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill enters whichever end the shift direction vacates.
  assign usr_MSB_in = fill_reg & ~dir_reg;
  assign usr_LSB_in = fill_reg & dir_reg;
  assign ser_bit    = dir_reg ? usr_Q[n-1] : usr_Q[0];

endmodule
